mul_seq: RTL
============

// Module: mul_seq
// PURPOSE
//   Multi-cycle 2N x 2N multiplier controller that time-shares one N x N array multiplier (mul).
//   Splits each operand into N-bit halves and issues the 4 partial products serially.
//   Shifts and accumulates them into a 4N-bit result. Signed mode uses sign-magnitude.
//   Sits between the ALU issue logic and the writeback path.
//   Valid/ready handshake on both sides; one operation in flight.
// PARAMETERS
//   N_BIT  4        chunk width of the shared mul array
//   W      2*N_BIT  operand width (fixed relation, not overridable)
// PORTS
//   clk        in   1      clock; all state on rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operation request
//   in_ready   out  1      controller can accept (high only in IDLE)
//   op_a       in   W      multiplicand
//   op_b       in   W      multiplier
//   is_signed  in   1      1: two's-complement operands/result; 0: unsigned
//   out_valid  out  1      result available
//   out_ready  in   1      consumer takes result
//   result     out  2*W    product; two's complement when is_signed captured as 1
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, acc=0, result=0, out_valid=0, in_ready=1, step=0.
//   FSM: IDLE -> MUL (4 cycles, step 0..3) -> FIX -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&in_ready edge E0, latch:
//     - mag_a=|op_a|, mag_b=|op_b| if is_signed, else raw operands.
//     - neg=is_signed&(op_a[W-1]^op_b[W-1]).
//     - acc=0, step=0.
//     - |-2^(W-1)| = 2^(W-1) fits unsigned in W bits; no overflow.
//   MUL: the mul instance always runs with mul_type=0 (unsigned).
//     - A = mag_a chunk step[0], B = mag_b chunk step[1].
//     - acc += product << ((step[0]+step[1])*N_BIT), all at 2W bits; no carry out of 2W possible.
//     - step increments; after step 3 go to FIX.
//   FIX: result = neg ? -acc : acc (2W-bit two's complement). out_valid=1 from next edge; DONE.
//   DONE: result and out_valid held stable while out_ready=0. On out_valid&out_ready: out_valid=0, IDLE.
//   Latency: result visible 6 edges after accept (E0 accept, E1..E4 MUL, E5 FIX, out_valid seen after E5).
//     Throughput one op per 7 cycles with out_ready=1.
//   in_valid while not IDLE: ignored, in_ready=0, operands not sampled.
//   Operands may change after E0 without effect.
//   Zero operand: result 0, neg ignored (-0=0), same latency.
//   rst mid-operation (any state): immediate abort to reset values; no out_valid pulse, partial acc discarded.
//   in_valid and out_ready same cycle in DONE: only the output handshake completes; the new op is accepted next cycle in IDLE.
// STRUCTURE
//   Shared package: state enum (IDLE, MUL, FIX, DONE), N_BIT default, W and 2*W width localparams.
//   One sub-module: mul (existing N x N array multiplier), instantiated once, mul_type tied 0.
//   Everything else (FSM, step counter, magnitude/negate logic, accumulator) is local to mul_seq.
// TESTING
//   Unsigned: op_a=8'hFF, op_b=8'hFF, is_signed=0 -> result=16'hFE01 after 6 edges; out_valid 1 cycle with out_ready=1.
//   Signed: op_a=-128 (8'h80), op_b=-128, is_signed=1 -> 16'h4000; op_a=8'h80, op_b=8'h7F -> 16'hC080 (-16256).
//   Backpressure: op_a=3, op_b=-5 signed, out_ready=0 for 10 cycles -> result=16'hFFF1 held stable, in_ready=0; release -> out_valid drops, IDLE.
//   Busy ignore: in_valid held with new operands during MUL -> first result unaffected; second op accepted only after DONE->IDLE.
//   Reset mid-op: assert rst during MUL step 2 -> out_valid=0, result=0, in_ready=1 immediately (async); next op 7x9 unsigned -> 16'd63.
//   Random: 1000 random op_a/op_b/is_signed vs reference model; check result and exact 6-edge latency.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types and widths for the sequential 2N x 2N multiplier controller.
// Operand width is always twice the chunk width of the shared multiplier array.
package mul_seq_pkg;

    localparam int N_BIT = 4;
    localparam int W     = 2 * N_BIT;
    localparam int W2    = 2 * W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // |v| when signed; the most negative value maps to 2^(W-1), which still fits unsigned in W bits.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic is_signed);
        return (is_signed && v[W-1]) ? (~v + W'(1)) : v;
    endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Request/response bundle between the ALU issue logic, the multiplier controller and writeback.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// the sender holds its payload stable while valid=1 and ready=0, and ready never depends on valid.
interface mul_seq_if;
    import mul_seq_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          is_signed;
    logic          out_valid;
    logic          out_ready;
    logic [W2-1:0] result;

    modport master (
        output in_valid, op_a, op_b, is_signed, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op_a, op_b, is_signed, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/mul_seq_mul.sv
// Combinational N x N array multiplier shared by the controller.
// mul_type=0 gives the unsigned product, mul_type=1 the two's-complement product.
module mul
    import mul_seq_pkg::*;
#(
    parameter int NB = N_BIT
) (
    input  logic [NB-1:0]   a,
    input  logic [NB-1:0]   b,
    input  logic            mul_type,
    output logic [2*NB-1:0] p
);

    logic [2*NB-1:0] u_sum;
    logic [2*NB-1:0] s_prod;

    // Shift-and-add rows of the array, one row per multiplier bit.
    always_comb begin
        u_sum = '0;
        for (int i = 0; i < NB; i++) begin
            if (b[i]) begin
                u_sum = u_sum + ({{NB{1'b0}}, a} << i);
            end
        end
    end

    assign s_prod = $signed({{NB{a[NB-1]}}, a}) * $signed({{NB{b[NB-1]}}, b});
    assign p      = mul_type ? s_prod : u_sum;

endmodule

// File: rtl/mul_seq.sv
// Multi-cycle 2N x 2N multiplier: four unsigned N x N partial products on one shared array,
// shift-accumulated into a 2W-bit result; signed operands handled in sign-magnitude form.
module mul_seq
    import mul_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mul_seq_if.slave   bus,
    output state_t     state_dbg
);

    state_t        state;
    state_t        state_nx;
    logic [1:0]    step;
    logic [W-1:0]  mag_a;
    logic [W-1:0]  mag_b;
    logic          neg;
    logic [W2-1:0] acc;
    logic [W2-1:0] result_r;
    logic          out_valid_r;

    logic [N_BIT-1:0]   chunk_a;
    logic [N_BIT-1:0]   chunk_b;
    logic [2*N_BIT-1:0] prod;
    logic [W2-1:0]      pp_shifted;

    // step[0] picks the half of A, step[1] the half of B.
    assign chunk_a = step[0] ? mag_a[W-1:N_BIT] : mag_a[N_BIT-1:0];
    assign chunk_b = step[1] ? mag_b[W-1:N_BIT] : mag_b[N_BIT-1:0];

    mul #(.NB(N_BIT)) u_mul (
        .a        (chunk_a),
        .b        (chunk_b),
        .mul_type (1'b0),
        .p        (prod)
    );

    always_comb begin
        pp_shifted = {{W{1'b0}}, prod};
        case (step)
            2'd1, 2'd2: pp_shifted = {{W{1'b0}}, prod} << N_BIT;
            2'd3:       pp_shifted = {{W{1'b0}}, prod} << (2 * N_BIT);
            default:    pp_shifted = {{W{1'b0}}, prod};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid)    state_nx = MUL;
            MUL:     if (step == 2'd3)    state_nx = FIX;
            FIX:                          state_nx = DONE;
            DONE:    if (bus.out_ready)   state_nx = IDLE;
            default:                      state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step        <= 2'd0;
            mag_a       <= '0;
            mag_b       <= '0;
            neg         <= 1'b0;
            acc         <= '0;
            result_r    <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mag_a <= magnitude(bus.op_a, bus.is_signed);
                        mag_b <= magnitude(bus.op_b, bus.is_signed);
                        neg   <= bus.is_signed & (bus.op_a[W-1] ^ bus.op_b[W-1]);
                        acc   <= '0;
                        step  <= 2'd0;
                    end
                end
                MUL: begin
                    // Wraps back to 0 after the last partial product.
                    acc  <= acc + pp_shifted;
                    step <= step + 2'd1;
                end
                FIX: begin
                    result_r    <= neg ? (~acc + W2'(1)) : acc;
                    out_valid_r <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign state_dbg     = state;

endmodule
